// File: rtl/jtag_debug_cmd_sysclk_if.sv
// Command bus between the system-clock JTAG command receiver and the OCI debug slaves.
// master = receiver side, slave = debug-slave side.
interface jtag_debug_cmd_sysclk_if #(
  parameter int unsigned SR_WIDTH  = 38,
  parameter int unsigned IR_WIDTH  = 2,
  parameter int unsigned CNT_WIDTH = 8
);
  localparam int unsigned NUM_CH = 2 ** IR_WIDTH;

  logic [SR_WIDTH-1:0]  jdo;
  logic [IR_WIDTH-1:0]  ir_sel;
  logic [NUM_CH-1:0]    cmd_valid;
  logic                 cmd_action;
  logic [NUM_CH-1:0]    cmd_ready;
  logic [NUM_CH-1:0]    overrun;
  logic                 overrun_clr;
  logic [CNT_WIDTH-1:0] cmd_count;

  modport master (
    output jdo, ir_sel, cmd_valid, cmd_action, overrun, cmd_count,
    input  cmd_ready, overrun_clr
  );

  modport slave (
    input  jdo, ir_sel, cmd_valid, cmd_action, overrun, cmd_count,
    output cmd_ready, overrun_clr
  );
endinterface

// File: rtl/jtag_debug_cmd_sysclk.sv
// System-clock side of a virtual-JTAG debug port: synchronises update-IR/DR strobes,
// captures the shifted DR and presents it as a one-hot per-channel command with overrun tracking.
module jtag_debug_cmd_sysclk #(
  parameter int unsigned SR_WIDTH    = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACTION_BIT  = 35,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vs_udr,
  input  logic                vs_uir,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [SR_WIDTH-1:0] sr,
  jtag_debug_cmd_sysclk_if.master cmd
);
  localparam int unsigned NUM_CH = 2 ** IR_WIDTH;

  typedef enum logic {IDLE, PEND} state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                 udr_edge, uir_edge;
  logic                 udr_rise, uir_rise;
  logic [IR_WIDTH-1:0]  ch;
  logic [IR_WIDTH-1:0]  ir_q;
  logic [SR_WIDTH-1:0]  jdo_q;
  logic                 act_q;
  logic [NUM_CH-1:0]    valid_q;
  logic [NUM_CH-1:0]    ovr_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 accept_c;
  logic [NUM_CH-1:0]    sel_c;
  logic [NUM_CH-1:0]    ovr_set_c;

  // Strobe synchronisers; rise pulses are registered so they are glitch-free single-cycle events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_edge <= 1'b0;
      uir_edge <= 1'b0;
      udr_rise <= 1'b0;
      uir_rise <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_edge <= udr_sync[SYNC_STAGES-1];
      uir_edge <= uir_sync[SYNC_STAGES-1];
      udr_rise <= udr_sync[SYNC_STAGES-1] & ~udr_edge;
      uir_rise <= uir_sync[SYNC_STAGES-1] & ~uir_edge;
    end
  end

  always_comb begin
    accept_c  = 1'b0;
    sel_c     = NUM_CH'(1) << ir_q;
    ovr_set_c = '0;
    if (state == PEND) begin
      accept_c = cmd.cmd_ready[ch];
    end
    // A new DR update that cannot be taken is dropped and flagged against its would-be channel.
    if ((state == PEND) && udr_rise && !accept_c) begin
      ovr_set_c = sel_c;
    end
  end

  // Command FSM with registered outputs; the decode always uses the IR latched before this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ch      <= '0;
      ir_q    <= '0;
      jdo_q   <= '0;
      act_q   <= 1'b0;
      valid_q <= '0;
      ovr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (uir_rise) begin
        ir_q <= ir_in;
      end
      ovr_q <= (ovr_q & ~{NUM_CH{cmd.overrun_clr}}) | ovr_set_c;
      if (accept_c) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (udr_rise) begin
            state   <= PEND;
            ch      <= ir_q;
            jdo_q   <= sr;
            act_q   <= sr[ACTION_BIT];
            valid_q <= sel_c;
          end
        end
        PEND: begin
          if (udr_rise && accept_c) begin
            ch      <= ir_q;
            jdo_q   <= sr;
            act_q   <= sr[ACTION_BIT];
            valid_q <= sel_c;
          end else if (accept_c) begin
            state   <= IDLE;
            valid_q <= '0;
          end
        end
      endcase
    end
  end

  assign cmd.jdo        = jdo_q;
  assign cmd.ir_sel     = ir_q;
  assign cmd.cmd_valid  = valid_q;
  assign cmd.cmd_action = act_q;
  assign cmd.overrun    = ovr_q;
  assign cmd.cmd_count  = cnt_q;
endmodule
